// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: connection bundle between the board RX pin, the receiver
// and the byte-consuming logic.
//   i_rx          serial line, idle high, asynchronous to clk
//   o_data        last delivered payload (DATA_BITS wide, LSB first on the wire)
//   o_valid       one-cycle strobe, o_data updated
//   o_parity_err  one-cycle, aligned with o_valid, parity mismatch
//   o_frame_err   one-cycle, aligned with o_valid, stop bit sampled low
//   o_break       one-cycle strobe, break condition detected
//   o_conn        line-alive status
// master: the receiver side. slave: the pin driver / payload consumer side.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break;
  logic                 o_conn;

  modport master (
    input  i_rx,
    output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_conn
  );

  modport slave (
    output i_rx,
    input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_conn
  );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with per-frame parity, framing and break reporting.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   uart_rx_frame_if.master (i_rx in; o_data, o_valid, o_parity_err,
//         o_frame_err, o_break, o_conn out)
module uart_rx_frame #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_frame_if.master bus
);

  if (CLK_PER_BIT < 4) begin : g_chk_cpb
    $error("uart_rx_frame: CLK_PER_BIT must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
    $error("uart_rx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_rx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int H  = (CLK_PER_BIT - 1) / 2;

  typedef enum logic [2:0] {
    S_LOST, S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;   // XOR of data and parity samples
  logic                 one_q, one_d;   // any data/parity sample was 1
  logic                 s1_q, rxs_q;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 conn;
  logic                 bit_end;
  logic                 perr_calc;

  assign bit_end   = (cnt_q == CW'(CLK_PER_BIT - 1));
  // Odd mode wants an odd number of ones (XOR = 1); even mode wants XOR = 0.
  assign perr_calc = (PARITY == 1) ? ~par_q : (PARITY == 2) ? par_q : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      rxs_q   <= 1'b0;
      state_q <= S_LOST;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      one_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      s1_q    <= bus.i_rx;
      rxs_q   <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      one_q   <= one_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    par_d   = par_q;
    one_d   = one_q;
    case (state_q)
      S_LOST: begin
        cnt_d  = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (rxs_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CW'(H)) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            par_d   = 1'b0;
            one_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
          par_d = par_q ^ rxs_q;
          one_d = one_q | rxs_q;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            stop_d  = 1'b0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PAR: begin
        if (bit_end) begin
          cnt_d   = '0;
          par_d   = par_q ^ rxs_q;
          one_d   = one_q | rxs_q;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = S_LOST;
          end else if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = S_DONE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_LOST;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;
    conn    = (state_q != S_LOST);
    case (state_q)
      S_STOP: begin
        // A low stop sample is reported on the sampling edge itself; an
        // all-zero frame is a break rather than a payload.
        if (bit_end && !rxs_q) begin
          if (!one_q) begin
            brk_d = 1'b1;
          end else begin
            data_d  = sh_q;
            valid_d = 1'b1;
            ferr_d  = 1'b1;
            perr_d  = perr_calc;
          end
        end
      end
      S_DONE: begin
        data_d  = sh_q;
        valid_d = 1'b1;
        perr_d  = perr_calc;
      end
      default: ;
    endcase
  end

  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_frame_err  = ferr_q;
  assign bus.o_break      = brk_q;
  assign bus.o_conn       = conn;

endmodule
